// File: rtl/mem_reg_engine.sv
// Instruction engine that moves words between an internal write-first RAM and a register bank.
// Every instruction takes two cycles: it is accepted in IDLE and completes in ACCESS.
//
//   state  | meaning
//   -------+-----------------------------------------------------------------
//   IDLE   | ready for an instruction; a store writes the RAM on the accept edge
//   ACCESS | publish the read word on out/err/out_valid; a load writes the register bank
module mem_reg_engine #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 16,
    parameter int NREG   = 8,
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int REG_AW = (NREG > 1) ? $clog2(NREG) : 1,
    localparam int INST_W = 2 + ADDR_W + DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [INST_W-1:0] inst,
    input  logic              inst_valid,
    output logic              inst_ready,
    output logic [DATA_W-1:0] out,
    output logic              out_valid,
    output logic              err
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam logic [1:0] OP_LOAD = 2'b10;

    state_t             state_q, state_d;
    logic [1:0]         op_q;
    logic [REG_AW-1:0]  idx_q;
    logic               oor_q;
    logic               idx_ok_q;
    logic [DATA_W-1:0]  rdata_q;
    logic [DATA_W-1:0]  out_q;
    logic               out_valid_q;
    logic               err_q;
    logic [DATA_W-1:0]  mem [DEPTH];
    logic [DATA_W-1:0]  regs_q [NREG];

    logic [1:0]         op_w;
    logic [ADDR_W-1:0]  addr_w;
    logic [DATA_W-1:0]  opnd_w;
    logic [REG_AW-1:0]  idx_w;
    logic               addr_ok;
    logic               idx_ok;
    logic               accept;
    logic               complete;
    logic               mem_we;
    logic [DATA_W-1:0]  wdata;

    assign op_w   = inst[INST_W-1 -: 2];
    assign addr_w = inst[DATA_W +: ADDR_W];
    assign opnd_w = inst[DATA_W-1:0];
    assign idx_w  = opnd_w[DATA_W-1 -: REG_AW];

    // Compare at 32 bits so the checks stay meaningful whether or not DEPTH/NREG are powers of two.
    assign addr_ok = ({{(32-ADDR_W){1'b0}}, addr_w} < 32'(DEPTH));
    assign idx_ok  = ({{(32-REG_AW){1'b0}}, idx_w} < 32'(NREG));

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        complete = 1'b0;
        mem_we   = 1'b0;
        wdata    = opnd_w;
        if (op_w == 2'b01) begin
            wdata = idx_ok ? regs_q[idx_w] : '0;
        end
        case (state_q)
            IDLE: begin
                if (inst_valid && !rst) begin
                    accept  = 1'b1;
                    mem_we  = addr_ok && !op_w[1];
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                complete = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Memory contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr_w] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= '0;
            idx_q       <= '0;
            oor_q       <= 1'b0;
            idx_ok_q    <= 1'b0;
            rdata_q     <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            out_valid_q <= complete;
            if (accept) begin
                op_q     <= op_w;
                idx_q    <= idx_w;
                oor_q    <= !addr_ok;
                idx_ok_q <= idx_ok;
                if (!addr_ok) begin
                    rdata_q <= '0;
                end else if (mem_we) begin
                    rdata_q <= wdata;
                end else begin
                    rdata_q <= mem[addr_w];
                end
            end
            if (complete) begin
                out_q <= rdata_q;
                err_q <= oor_q;
                if (op_q == OP_LOAD && !oor_q && idx_ok_q) begin
                    regs_q[idx_q] <= rdata_q;
                end
            end
        end
    end

    assign inst_ready = (state_q == IDLE);
    assign out        = out_q;
    assign out_valid  = out_valid_q;
    assign err        = err_q;

endmodule

// File: tb/tb_mem_reg_engine.sv
// Randomised bench for mem_reg_engine with a non-power-of-two memory (12 words) and register bank (6).
// Expected results come from an array-based instruction model kept here.
module tb_mem_reg_engine;

    localparam int DATA_W = 4;
    localparam int DEPTH  = 12;
    localparam int NREG   = 6;
    localparam int ADDR_W = 4;
    localparam int INST_W = 2 + ADDR_W + DATA_W;

    logic              clk = 1'b0;
    logic              rst;
    logic [INST_W-1:0] inst;
    logic              inst_valid;
    logic              inst_ready;
    logic [DATA_W-1:0] out;
    logic              out_valid;
    logic              err;

    always #5 clk = ~clk;

    mem_reg_engine #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NREG(NREG)) dut (
        .clk        (clk),
        .rst        (rst),
        .inst       (inst),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .out        (out),
        .out_valid  (out_valid),
        .err        (err)
    );

    int n_chk   = 0;
    int n_err   = 0;
    int n_done  = 0;
    int n_pulse = 0;
    logic [3:0] m_mem [16];
    logic [3:0] m_reg [8];
    logic [3:0] last_out = 4'h0;

    always @(posedge clk) begin
        if (out_valid === 1'b1) n_pulse++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Architectural effect of one instruction; returns the word and error flag it should report.
    task automatic model(input logic [1:0] op, input int addr, input logic [3:0] opnd,
                         output logic [3:0] eo, output logic ee);
        int idx;
        idx = int'(opnd) / 2;
        eo  = 4'h0;
        ee  = (addr >= DEPTH);
        if (addr < DEPTH) begin
            case (op)
                2'd0: m_mem[addr] = opnd;
                2'd1: m_mem[addr] = (idx < NREG) ? m_reg[idx] : 4'h0;
                2'd2: if (idx < NREG) m_reg[idx] = m_mem[addr];
                default: ;
            endcase
            eo = m_mem[addr];
        end
    endtask

    task automatic clear_regs();
        for (int i = 0; i < 8; i++) m_reg[i] = 4'h0;
    endtask

    task automatic issue(input logic [1:0] op, input int addr, input logic [3:0] opnd, input bit hold);
        int w;
        logic [3:0] eo;
        logic ee;
        w = 0;
        while (inst_ready !== 1'b1 && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        chk("ready_wait", {31'd0, inst_ready}, 32'd1);
        inst       = {op, 4'(addr), opnd};
        inst_valid = 1'b1;
        @(posedge clk); #1;
        model(op, addr, opnd, eo, ee);
        chk("ready_low", {31'd0, inst_ready}, 32'd0);
        chk("ov_low", {31'd0, out_valid}, 32'd0);
        if (!hold) inst_valid = 1'b0;
        @(posedge clk); #1;
        chk("ov", {31'd0, out_valid}, 32'd1);
        chk("out", {28'd0, out}, {28'd0, eo});
        chk("err", {31'd0, err}, {31'd0, ee});
        chk("ready_high", {31'd0, inst_ready}, 32'd1);
        last_out = eo;
        n_done++;
    endtask

    // Holds reset for two edges, optionally offering a store that must be ignored.
    task automatic do_reset(input bit junk);
        rst = 1'b1;
        if (junk) begin
            inst       = {2'b00, 4'd0, 4'hF};
            inst_valid = 1'b1;
        end
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("rst_ov", {31'd0, out_valid}, 32'd0);
        chk("rst_ready", {31'd0, inst_ready}, 32'd1);
        chk("rst_out", {28'd0, out}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        rst        = 1'b0;
        inst_valid = 1'b0;
        clear_regs();
        last_out = 4'h0;
    endtask

    initial begin
        logic [3:0] eo;
        logic ee;
        rst        = 1'b1;
        inst       = '0;
        inst_valid = 1'b0;
        clear_regs();
        for (int i = 0; i < 16; i++) m_mem[i] = 4'h0;
        @(posedge clk); #1;
        do_reset(1'b0);

        for (int a = 0; a < DEPTH; a++) issue(2'd0, a, 4'($urandom_range(0, 15)), 1'b0);

        // Back-to-back with inst_valid held high: store, display, load reg3, store reg3 elsewhere.
        issue(2'd0, 5, 4'hA, 1'b1);
        issue(2'd3, 5, 4'h0, 1'b1);
        issue(2'd2, 5, 4'h6, 1'b1);
        issue(2'd1, 9, 4'h6, 1'b0);

        // Addresses past the 12-word memory.
        issue(2'd0, 13, 4'h7, 1'b0);
        issue(2'd3, 13, 4'h0, 1'b0);
        issue(2'd3, 1, 4'h0, 1'b0);

        // Register indices 6 and 7 do not exist.
        issue(2'd1, 2, 4'hE, 1'b0);
        issue(2'd2, 3, 4'hC, 1'b0);
        issue(2'd1, 4, 4'hC, 1'b0);

        // Reset while a load into reg2 sits in ACCESS: the load must be lost.
        issue(2'd0, 5, 4'hB, 1'b0);
        inst       = {2'b10, 4'd5, 4'h4};
        inst_valid = 1'b1;
        @(posedge clk); #1;
        inst_valid = 1'b0;
        do_reset(1'b0);
        issue(2'd1, 9, 4'h4, 1'b0);

        // Memory keeps its contents across reset; a store offered during reset is ignored.
        issue(2'd0, 0, 4'h3, 1'b0);
        do_reset(1'b1);
        issue(2'd3, 0, 4'h0, 1'b0);

        for (int n = 0; n < 120; n++) begin
            bit hold;
            hold = 1'($urandom_range(0, 1));
            issue(2'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), hold);
            if (!hold) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                    chk("out_hold", {28'd0, out}, {28'd0, last_out});
                    chk("ov_idle", {31'd0, out_valid}, 32'd0);
                end
            end
        end

        inst_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("pulses", 32'(n_pulse), 32'(n_done));
        model(2'd3, 0, 4'h0, eo, ee);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
